rps_match_engine: RTL and testbench

- Parametrised best-of-N stone/paper/scissors match engine; successor to the single-round judge.
- Supports 3-move or 5-move rule sets and keeps per-player scores across rounds.
- Uses a valid/ready move handshake and declares a match winner when either player reaches ROUNDS_TO_WIN.
- Sits between the pad-level input decoder and the output mux; ascii_out drives the dedicated output bus directly.

---
 rtl/rps_pkg.sv | 39 +++
 rtl/rps_round_judge.sv | 32 +++
 rtl/rps_match_engine.sv | 154 +++++++++++++++
 tb/tb_rps_match_engine.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared definitions for the stone/paper/scissors match engine:
// result codes, their ASCII renderings, move encodings and FSM states.
package rps_pkg;

  localparam logic [1:0] RES_TIE = 2'b00;
  localparam logic [1:0] RES_P1  = 2'b01;
  localparam logic [1:0] RES_P2  = 2'b10;
  localparam logic [1:0] RES_INV = 2'b11;

  localparam logic [7:0] ASCII_TIE = 8'h00;
  localparam logic [7:0] ASCII_P1  = 8'h31;
  localparam logic [7:0] ASCII_P2  = 8'h32;
  localparam logic [7:0] ASCII_INV = 8'h3F;

  localparam logic [2:0] MOVE_STONE    = 3'd0;
  localparam logic [2:0] MOVE_PAPER    = 3'd1;
  localparam logic [2:0] MOVE_SCISSORS = 3'd2;
  localparam logic [2:0] MOVE_EXT3     = 3'd3;
  localparam logic [2:0] MOVE_EXT4     = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_JUDGE,
    ST_DONE
  } state_t;

  function automatic logic [7:0] result_ascii(input logic [1:0] res);
    logic [7:0] ch;
    case (res)
      RES_TIE: ch = ASCII_TIE;
      RES_P1:  ch = ASCII_P1;
      RES_P2:  ch = ASCII_P2;
      default: ch = ASCII_INV;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/rps_round_judge.sv
// Combinational single-round judge: d = (p1 - p2) mod NUM_MOVES,
// 0 = tie, odd = P1, even nonzero = P2; out-of-range moves are invalid.
module rps_round_judge
  import rps_pkg::*;
#(
  parameter int unsigned NUM_MOVES = 3
) (
  input  logic [2:0] p1_move,
  input  logic [2:0] p2_move,
  output logic [1:0] result
);

  localparam logic [3:0] NM = 4'(NUM_MOVES);

  logic [3:0] diff;

  always_comb begin
    result = RES_TIE;
    diff   = '0;
    if ({1'b0, p1_move} >= NM || {1'b0, p2_move} >= NM) begin
      result = RES_INV;
    end else begin
      // Modular difference without a divider: wrap by adding NM when negative.
      if (p1_move >= p2_move) diff = {1'b0, p1_move} - {1'b0, p2_move};
      else                    diff = {1'b0, p1_move} + NM - {1'b0, p2_move};
      if (diff == '0)   result = RES_TIE;
      else if (diff[0]) result = RES_P1;
      else              result = RES_P2;
    end
  end

endmodule

// File: rtl/rps_match_engine.sv
// Best-of-N stone/paper/scissors match engine with per-player scores.
// Optional tie-limit draw enabled by defining RPS_TIE_LIMIT_EN.
module rps_match_engine
  import rps_pkg::*;
#(
  parameter int unsigned NUM_MOVES     = 3,
  parameter int unsigned ROUNDS_TO_WIN = 3,
  parameter int unsigned TIE_LIMIT     = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       start,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [2:0] p1_move,
  input  logic [2:0] p2_move,
  output logic       result_valid,
  output logic [1:0] round_result,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       match_done,
  output logic [1:0] match_winner,
  output logic [7:0] ascii_out
);

  if (NUM_MOVES != 3 && NUM_MOVES != 5) begin : g_bad_moves
    $error("rps_match_engine: NUM_MOVES must be 3 or 5");
  end
  if (ROUNDS_TO_WIN < 1 || ROUNDS_TO_WIN > 15) begin : g_bad_rounds
    $error("rps_match_engine: ROUNDS_TO_WIN must be 1..15");
  end
  if (TIE_LIMIT < 1 || TIE_LIMIT > 15) begin : g_bad_ties
    $error("rps_match_engine: TIE_LIMIT must be 1..15");
  end

  localparam logic [3:0] WIN_SCORE = 4'(ROUNDS_TO_WIN);

  state_t     state;
  logic [2:0] p1_q;
  logic [2:0] p2_q;
  logic [1:0] judge_res;
  logic [3:0] p1_inc;
  logic [3:0] p2_inc;

  rps_round_judge #(.NUM_MOVES(NUM_MOVES)) u_judge (
    .p1_move (p1_q),
    .p2_move (p2_q),
    .result  (judge_res)
  );

  always_comb begin
    move_ready = ena && (state == ST_WAIT);
    p1_inc     = score_p1 + 4'd1;
    p2_inc     = score_p2 + 4'd1;
  end

`ifdef RPS_TIE_LIMIT_EN
  localparam logic [3:0] TIE_MAX = 4'(TIE_LIMIT);
  logic [3:0] tie_cnt;
  logic [3:0] tie_inc;
  always_comb tie_inc = tie_cnt + 4'd1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      p1_q         <= '0;
      p2_q         <= '0;
      result_valid <= 1'b0;
      round_result <= '0;
      score_p1     <= '0;
      score_p2     <= '0;
      match_done   <= 1'b0;
      match_winner <= '0;
      ascii_out    <= '0;
`ifdef RPS_TIE_LIMIT_EN
      tie_cnt      <= '0;
`endif
    end else if (ena) begin
      result_valid <= 1'b0;
      // start wins over any handshake and discards a round sitting in JUDGE
      if (start) begin
        state        <= ST_WAIT;
        round_result <= RES_TIE;
        score_p1     <= '0;
        score_p2     <= '0;
        match_done   <= 1'b0;
        match_winner <= RES_TIE;
        ascii_out    <= ASCII_TIE;
`ifdef RPS_TIE_LIMIT_EN
        tie_cnt      <= '0;
`endif
      end else begin
        case (state)
          ST_WAIT: begin
            if (move_valid) begin
              p1_q  <= p1_move;
              p2_q  <= p2_move;
              state <= ST_JUDGE;
            end
          end
          ST_JUDGE: begin
            result_valid <= 1'b1;
            round_result <= judge_res;
            ascii_out    <= result_ascii(judge_res);
            state        <= ST_WAIT;
            case (judge_res)
              RES_P1: begin
                score_p1 <= p1_inc;
                if (p1_inc == WIN_SCORE) begin
                  state        <= ST_DONE;
                  match_done   <= 1'b1;
                  match_winner <= RES_P1;
                end
`ifdef RPS_TIE_LIMIT_EN
                tie_cnt <= '0;
`endif
              end
              RES_P2: begin
                score_p2 <= p2_inc;
                if (p2_inc == WIN_SCORE) begin
                  state        <= ST_DONE;
                  match_done   <= 1'b1;
                  match_winner <= RES_P2;
                end
`ifdef RPS_TIE_LIMIT_EN
                tie_cnt <= '0;
`endif
              end
              RES_TIE: begin
`ifdef RPS_TIE_LIMIT_EN
                tie_cnt <= tie_inc;
                if (tie_inc == TIE_MAX) begin
                  state        <= ST_DONE;
                  match_done   <= 1'b1;
                  match_winner <= RES_TIE;
                end
`endif
              end
              default: begin
`ifdef RPS_TIE_LIMIT_EN
                tie_cnt <= '0;
`endif
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rps_match_engine.sv
// Self-checking bench: a 3-move and a 5-move engine, table vectors,
// hand-written corner sequences and random rounds against a rule model.
module tb_rps_match_engine;

  localparam int R  = 3;
  localparam int TL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            ena;
  logic [1:0]      start;
  logic [1:0]      move_valid;
  logic [1:0][2:0] p1m;
  logic [1:0][2:0] p2m;
  logic [1:0]      move_ready;
  logic [1:0]      result_valid;
  logic [1:0]      match_done;
  logic [1:0][1:0] round_result;
  logic [1:0][1:0] match_winner;
  logic [1:0][3:0] score_p1;
  logic [1:0][3:0] score_p2;
  logic [1:0][7:0] ascii;

  rps_match_engine #(.NUM_MOVES(3), .ROUNDS_TO_WIN(R), .TIE_LIMIT(TL)) dut3 (
    .clk(clk), .rst(rst), .ena(ena), .start(start[0]),
    .move_valid(move_valid[0]), .move_ready(move_ready[0]),
    .p1_move(p1m[0]), .p2_move(p2m[0]),
    .result_valid(result_valid[0]), .round_result(round_result[0]),
    .score_p1(score_p1[0]), .score_p2(score_p2[0]),
    .match_done(match_done[0]), .match_winner(match_winner[0]),
    .ascii_out(ascii[0])
  );

  rps_match_engine #(.NUM_MOVES(5), .ROUNDS_TO_WIN(R), .TIE_LIMIT(TL)) dut5 (
    .clk(clk), .rst(rst), .ena(ena), .start(start[1]),
    .move_valid(move_valid[1]), .move_ready(move_ready[1]),
    .p1_move(p1m[1]), .p2_move(p2m[1]),
    .result_valid(result_valid[1]), .round_result(round_result[1]),
    .score_p1(score_p1[1]), .score_p2(score_p2[1]),
    .match_done(match_done[1]), .match_winner(match_winner[1]),
    .ascii_out(ascii[1])
  );

  int checks = 0;
  int fails  = 0;

  // Reference model state per engine
  int nmv[2] = '{3, 5};
  int s1[2], s2[2], ties[2], done[2], win[2], last_res[2], started[2];

  typedef struct {
    int dut;
    int new_match;
    int a;
    int b;
    int exp_res;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (dut%0d): got 0x%0h expected 0x%0h", name, i, act, exp);
    end
  endtask

  function automatic int judge(input int nm, input int a, input int b);
    int d;
    if (a >= nm || b >= nm) return 3;
    d = ((a - b) % nm + nm) % nm;
    if (d == 0) return 0;
    return (d % 2 == 1) ? 1 : 2;
  endfunction

  function automatic int to_ascii(input int r);
    case (r)
      0: return 'h00;
      1: return 'h31;
      2: return 'h32;
      default: return 'h3F;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear(input int i);
    s1[i] = 0; s2[i] = 0; ties[i] = 0; done[i] = 0; win[i] = 0; last_res[i] = 0;
  endtask

  task automatic model_apply(input int i, input int r);
    last_res[i] = r;
    case (r)
      1: begin s1[i]++; ties[i] = 0; if (s1[i] == R) begin done[i] = 1; win[i] = 1; end end
      2: begin s2[i]++; ties[i] = 0; if (s2[i] == R) begin done[i] = 1; win[i] = 2; end end
      3: ties[i] = 0;
      default: begin
        ties[i]++;
`ifdef RPS_TIE_LIMIT_EN
        if (ties[i] == TL) begin done[i] = 1; win[i] = 0; end
`endif
      end
    endcase
  endtask

  task automatic check_state(input int i, input string tag);
    chk({tag, "_score_p1"}, i, 8'(score_p1[i]), 8'(s1[i]));
    chk({tag, "_score_p2"}, i, 8'(score_p2[i]), 8'(s2[i]));
    chk({tag, "_match_done"}, i, 8'(match_done[i]), 8'(done[i]));
    chk({tag, "_match_winner"}, i, 8'(match_winner[i]), 8'(win[i]));
    chk({tag, "_round_result"}, i, 8'(round_result[i]), 8'(last_res[i]));
    chk({tag, "_ascii"}, i, ascii[i], 8'(to_ascii(last_res[i])));
    chk({tag, "_move_ready"}, i, 8'(move_ready[i]), 8'(started[i] != 0 && done[i] == 0 && ena));
  endtask

  task automatic start_match(input int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
    model_clear(i);
    started[i] = 1;
    chk("start_rv", i, 8'(result_valid[i]), 8'd0);
    check_state(i, "start");
  endtask

  task automatic handshake(input int i, input int a, input int b, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!move_ready[i] && n < 20) begin tick(); n++; end
    if (!move_ready[i]) begin
      chk("ready_timeout", i, 8'(move_ready[i]), 8'd1);
      return;
    end
    p1m[i] = 3'(a);
    p2m[i] = 3'(b);
    move_valid[i] = 1'b1;
    tick();
    move_valid[i] = 1'b0;
    ok = 1'b1;
  endtask

  task automatic play(input int i, input int a, input int b);
    bit ok;
    handshake(i, a, b, ok);
    if (!ok) return;
    chk("rv_in_judge", i, 8'(result_valid[i]), 8'd0);
    tick();
    model_apply(i, judge(nmv[i], a, b));
    chk("rv_pulse", i, 8'(result_valid[i]), 8'd1);
    check_state(i, "round");
    tick();
    chk("rv_pulse_end", i, 8'(result_valid[i]), 8'd0);
  endtask

  initial begin
    bit ok;
    rst = 1'b1; ena = 1'b1; start = '0; move_valid = '0; p1m = '0; p2m = '0;
    for (int i = 0; i < 2; i++) begin model_clear(i); started[i] = 0; end

    tbl[0] = '{0, 1, 1, 0, 1};
    tbl[1] = '{0, 0, 2, 1, 1};
    tbl[2] = '{0, 0, 0, 2, 1};
    tbl[3] = '{0, 1, 0, 0, 0};
    tbl[4] = '{0, 0, 3, 1, 3};
    tbl[5] = '{1, 1, 4, 0, 2};
    tbl[6] = '{1, 0, 3, 0, 1};
    tbl[7] = '{1, 0, 2, 4, 1};
    tbl[8] = '{1, 0, 5, 0, 3};

    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("reset_rv", i, 8'(result_valid[i]), 8'd0);
      check_state(i, "reset");
    end
    tick();
    chk("idle_not_ready", 0, 8'(move_ready[0]), 8'd0);

    for (int k = 0; k < 9; k++) begin
      if (tbl[k].new_match != 0) start_match(tbl[k].dut);
      play(tbl[k].dut, tbl[k].a, tbl[k].b);
      chk("tbl_result", tbl[k].dut, 8'(round_result[tbl[k].dut]), 8'(tbl[k].exp_res));
      chk("tbl_ascii", tbl[k].dut, ascii[tbl[k].dut], 8'(to_ascii(tbl[k].exp_res)));
      if (k == 2) begin
        chk("p1_match_done", 0, 8'(match_done[0]), 8'd1);
        chk("p1_match_winner", 0, 8'(match_winner[0]), 8'd1);
        chk("done_not_ready", 0, 8'(move_ready[0]), 8'd0);
      end
    end

    // start during JUDGE discards the round
    start_match(0);
    play(0, 1, 0);
    handshake(0, 2, 1, ok);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    model_clear(0);
    chk("abort_rv", 0, 8'(result_valid[0]), 8'd0);
    check_state(0, "abort");
    tick();
    chk("abort_rv_late", 0, 8'(result_valid[0]), 8'd0);

    // ena low while in JUDGE, then while the pulse is high
    handshake(0, 2, 1, ok);
    ena = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("frozen_rv", 0, 8'(result_valid[0]), 8'd0);
      chk("frozen_score", 0, 8'(score_p1[0]), 8'd0);
      chk("frozen_ready", 0, 8'(move_ready[0]), 8'd0);
    end
    ena = 1'b1;
    tick();
    model_apply(0, 1);
    chk("thaw_rv", 0, 8'(result_valid[0]), 8'd1);
    check_state(0, "thaw");
    ena = 1'b0;
    tick(); tick();
    chk("held_rv", 0, 8'(result_valid[0]), 8'd1);
    ena = 1'b1;
    tick();
    chk("held_rv_end", 0, 8'(result_valid[0]), 8'd0);

    // consecutive ties
    start_match(0);
    play(0, 1, 1);
    play(0, 2, 2);
`ifdef RPS_TIE_LIMIT_EN
    chk("tie_limit_done", 0, 8'(match_done[0]), 8'd1);
    chk("tie_limit_ready", 0, 8'(move_ready[0]), 8'd0);
`else
    chk("tie_no_limit_done", 0, 8'(match_done[0]), 8'd0);
    chk("tie_no_limit_ready", 0, 8'(move_ready[0]), 8'd1);
`endif
    chk("tie_winner", 0, 8'(match_winner[0]), 8'd0);

    // random rounds
    for (int k = 0; k < 200; k++) begin
      int i, a, b;
      i = int'($urandom_range(0, 1));
      if (started[i] == 0 || done[i] != 0 || $urandom_range(0, 11) == 0) start_match(i);
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 5) == 0) begin
        a = int'($urandom_range(0, 7)); b = int'($urandom_range(0, 7));
      end else begin
        a = int'($urandom_range(0, nmv[i] - 1)); b = int'($urandom_range(0, nmv[i] - 1));
      end
      play(i, a, b);
    end

    // reset in the middle of a round
    start_match(1);
    handshake(1, 3, 0, ok);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      model_clear(i);
      started[i] = 0;
      chk("midrst_rv", i, 8'(result_valid[i]), 8'd0);
      check_state(i, "midrst");
    end
    tick();
    chk("midrst_rv_late", 1, 8'(result_valid[1]), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
